// File: rtl/oq_header_parser_v2_pkg.sv
// Shared NF2 defines for the output-queue header parser: IOQ header field positions and FSM encoding.
// Optional statistics counters are enabled by defining OQ_HDR_PARSER_STATS_EN.
`ifndef IO_QUEUE_STAGE_NUM
`define IO_QUEUE_STAGE_NUM 'hff
`endif
`ifndef IOQ_BYTE_LEN_POS
`define IOQ_BYTE_LEN_POS 0
`endif
`ifndef IOQ_SRC_PORT_POS
`define IOQ_SRC_PORT_POS 16
`endif
`ifndef IOQ_WORD_LEN_POS
`define IOQ_WORD_LEN_POS 32
`endif
`ifndef IOQ_DST_PORT_POS
`define IOQ_DST_PORT_POS 48
`endif

package oq_header_parser_v2_pkg;

    typedef enum logic [2:0] {
        WAIT_HDR  = 3'd0,
        WAIT_DATA = 3'd1,
        WAIT_EOP  = 3'd2,
        DROP_DATA = 3'd3,
        DROP_EOP  = 3'd4
    } state_e;

endpackage

// File: rtl/oq_header_parser_v2_fallthrough_small_fifo.sv
// Small fall-through FIFO: head entry is presented combinationally on dout.
// A write while full is accepted only when a read empties a slot in the same cycle.
module fallthrough_small_fifo #(
    parameter int WIDTH          = 8,
    parameter int MAX_DEPTH_BITS = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [WIDTH-1:0]          din,
    input  logic                      wr_en,
    input  logic                      rd_en,
    output logic [WIDTH-1:0]          dout,
    output logic                      full,
    output logic                      empty,
    output logic [MAX_DEPTH_BITS:0]   count
);

    localparam int DEPTH = 2 ** MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] FULL_CNT = {1'b1, {MAX_DEPTH_BITS{1'b0}}};

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr;
    logic                      do_rd;
    logic                      do_wr;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/oq_header_parser_v2.sv
// Parses the IOQ module header of each packet into a descriptor FIFO for the output queues.
// Define OQ_HDR_PARSER_STATS_EN to add clr_stats and saturating error counters.
module oq_header_parser_v2
    import oq_header_parser_v2_pkg::*;
#(
    parameter int DATA_WIDTH        = 64,
    parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
    parameter int IOQ_STAGE_NUM     = `IO_QUEUE_STAGE_NUM,
    parameter int NUM_OUTPUT_QUEUES = 8,
    parameter int MAX_PKT           = 2048,
    parameter int SRC_PORT_WIDTH    = 16,
    parameter int FIFO_DEPTH_BITS   = 3,
    parameter int ERR_CNT_WIDTH     = 16,
    localparam int PKT_BYTE_CNT_WIDTH = $clog2(MAX_PKT),
    localparam int PKT_WORD_CNT_WIDTH = $clog2(MAX_PKT / CTRL_WIDTH)
) (
    input  logic                          clk,
    input  logic                          reset_n,
`ifdef OQ_HDR_PARSER_STATS_EN
    input  logic                          clr_stats,
    output logic [ERR_CNT_WIDTH-1:0]      missing_hdr_cnt,
    output logic [ERR_CNT_WIDTH-1:0]      bad_dst_cnt,
    output logic [ERR_CNT_WIDTH-1:0]      overflow_cnt,
`endif
    input  logic                          in_wr,
    input  logic [CTRL_WIDTH-1:0]         in_ctrl,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic [NUM_OUTPUT_QUEUES-1:0]  parsed_dst_oq,
    output logic [PKT_BYTE_CNT_WIDTH-1:0] parsed_pkt_byte_len,
    output logic [PKT_WORD_CNT_WIDTH-1:0] parsed_pkt_word_len,
    output logic [SRC_PORT_WIDTH-1:0]     parsed_src_port,
    output logic                          dst_oq_avail,
    input  logic                          rd_dst_oq,
    output logic                          header_parser_rdy,
    output logic [FIFO_DEPTH_BITS:0]      fifo_count,
    output logic                          err_missing_hdr,
    output logic                          err_bad_dst,
    output logic                          err_overflow,
    output logic [2:0]                    dbg_state
);

    localparam int DESC_W = NUM_OUTPUT_QUEUES + PKT_BYTE_CNT_WIDTH + PKT_WORD_CNT_WIDTH + SRC_PORT_WIDTH;

    state_e                         state;
    state_e                         next_state;
    logic                           is_ioq_hdr;
    logic [NUM_OUTPUT_QUEUES-1:0]   hdr_dst;
    logic [DESC_W-1:0]              desc_in;
    logic [DESC_W-1:0]              desc_out;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic                           fifo_wr;
    logic                           missing_d;
    logic                           bad_dst_d;
    logic                           overflow_d;
    logic                           unused_data;

    assign is_ioq_hdr = (in_ctrl == IOQ_STAGE_NUM[CTRL_WIDTH-1:0]);
    assign hdr_dst    = in_data[`IOQ_DST_PORT_POS +: NUM_OUTPUT_QUEUES];
    assign desc_in    = {hdr_dst,
                         in_data[`IOQ_BYTE_LEN_POS +: PKT_BYTE_CNT_WIDTH],
                         in_data[`IOQ_WORD_LEN_POS +: PKT_WORD_CNT_WIDTH],
                         in_data[`IOQ_SRC_PORT_POS +: SRC_PORT_WIDTH]};
    assign unused_data = ^in_data;
    assign dbg_state   = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= WAIT_HDR;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (in_wr) begin
            case (state)
                WAIT_HDR: begin
                    if (is_ioq_hdr) begin
                        if (hdr_dst == '0 || (fifo_full && !rd_dst_oq)) next_state = DROP_DATA;
                        else                                            next_state = WAIT_DATA;
                    end else if (in_ctrl == '0) begin
                        next_state = DROP_EOP;
                    end
                end
                WAIT_DATA: if (in_ctrl == '0) next_state = WAIT_EOP;
                DROP_DATA: if (in_ctrl == '0) next_state = DROP_EOP;
                WAIT_EOP,
                DROP_EOP:  if (in_ctrl != '0) next_state = WAIT_HDR;
                default:   next_state = WAIT_HDR;
            endcase
        end
    end

    // A full FIFO still accepts the header when the head is being popped in the same cycle.
    always_comb begin
        fifo_wr    = 1'b0;
        missing_d  = 1'b0;
        bad_dst_d  = 1'b0;
        overflow_d = 1'b0;
        if (in_wr && state == WAIT_HDR) begin
            if (is_ioq_hdr) begin
                if (hdr_dst == '0)                bad_dst_d  = 1'b1;
                else if (fifo_full && !rd_dst_oq) overflow_d = 1'b1;
                else                              fifo_wr    = 1'b1;
            end else if (in_ctrl == '0) begin
                missing_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_missing_hdr <= 1'b0;
            err_bad_dst     <= 1'b0;
            err_overflow    <= 1'b0;
        end else begin
            err_missing_hdr <= missing_d;
            err_bad_dst     <= bad_dst_d;
            err_overflow    <= overflow_d;
        end
    end

`ifdef OQ_HDR_PARSER_STATS_EN
    // Clear has priority over an increment landing in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            missing_hdr_cnt <= '0;
            bad_dst_cnt     <= '0;
            overflow_cnt    <= '0;
        end else if (clr_stats) begin
            missing_hdr_cnt <= '0;
            bad_dst_cnt     <= '0;
            overflow_cnt    <= '0;
        end else begin
            if (err_missing_hdr && missing_hdr_cnt != '1) missing_hdr_cnt <= missing_hdr_cnt + 1'b1;
            if (err_bad_dst && bad_dst_cnt != '1)         bad_dst_cnt     <= bad_dst_cnt + 1'b1;
            if (err_overflow && overflow_cnt != '1)       overflow_cnt    <= overflow_cnt + 1'b1;
        end
    end
`endif

    fallthrough_small_fifo #(
        .WIDTH          (DESC_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_desc_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (desc_in),
        .wr_en   (fifo_wr),
        .rd_en   (rd_dst_oq),
        .dout    (desc_out),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign {parsed_dst_oq, parsed_pkt_byte_len, parsed_pkt_word_len, parsed_src_port} = desc_out;
    assign dst_oq_avail      = !fifo_empty;
    assign header_parser_rdy = !fifo_full;

endmodule

// File: tb/tb_oq_header_parser_v2.sv
// Directed bench for oq_header_parser_v2: parsing, error pulses, full-FIFO corner cases, async reset.
module tb_oq_header_parser_v2;
    import oq_header_parser_v2_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_wr;
    logic [7:0]  in_ctrl;
    logic [63:0] in_data;
    logic [7:0]  parsed_dst_oq;
    logic [10:0] parsed_pkt_byte_len;
    logic [7:0]  parsed_pkt_word_len;
    logic [15:0] parsed_src_port;
    logic        dst_oq_avail;
    logic        rd_dst_oq;
    logic        header_parser_rdy;
    logic [3:0]  fifo_count;
    logic        err_missing_hdr;
    logic        err_bad_dst;
    logic        err_overflow;
    logic [2:0]  dbg_state;
`ifdef OQ_HDR_PARSER_STATS_EN
    logic        clr_stats;
    logic [15:0] missing_hdr_cnt;
    logic [15:0] bad_dst_cnt;
    logic [15:0] overflow_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];
    logic [10:0] exp_len;

    oq_header_parser_v2 dut (
        .clk                 (clk),
        .reset_n             (reset_n),
`ifdef OQ_HDR_PARSER_STATS_EN
        .clr_stats           (clr_stats),
        .missing_hdr_cnt     (missing_hdr_cnt),
        .bad_dst_cnt         (bad_dst_cnt),
        .overflow_cnt        (overflow_cnt),
`endif
        .in_wr               (in_wr),
        .in_ctrl             (in_ctrl),
        .in_data             (in_data),
        .parsed_dst_oq       (parsed_dst_oq),
        .parsed_pkt_byte_len (parsed_pkt_byte_len),
        .parsed_pkt_word_len (parsed_pkt_word_len),
        .parsed_src_port     (parsed_src_port),
        .dst_oq_avail        (dst_oq_avail),
        .rd_dst_oq           (rd_dst_oq),
        .header_parser_rdy   (header_parser_rdy),
        .fifo_count          (fifo_count),
        .err_missing_hdr     (err_missing_hdr),
        .err_bad_dst         (err_bad_dst),
        .err_overflow        (err_overflow),
        .dbg_state           (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // driver tasks: inputs change 1 ns after the rising edge, outputs are sampled there too
    task automatic send(input logic [7:0] c, input logic [63:0] d);
        in_wr   = 1'b1;
        in_ctrl = c;
        in_data = d;
        @(posedge clk);
        #1;
        in_wr   = 1'b0;
        in_ctrl = 8'h00;
        in_data = 64'h0;
    endtask

    task automatic send_hdr(input logic [7:0] dst, input logic [10:0] bytes,
                            input logic [7:0] words, input logic [15:0] src);
        send(8'hff, {8'h00, dst, 8'h00, words, src, 5'h00, bytes});
    endtask

    task automatic send_body(input int n);
        for (int i = 0; i < n - 1; i++) send(8'h00, 64'hdada_0000_0000_0000 + 64'(i));
        send(8'h80, 64'hee00_0000_0000_00ff);
    endtask

    task automatic pop();
        rd_dst_oq = 1'b1;
        @(posedge clk);
        #1;
        rd_dst_oq = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d want 0", fifo_count); end
        checks++; if (dst_oq_avail !== 1'b0) begin errors++; $display("FAIL rst_avail got %0b want 0", dst_oq_avail); end
        checks++; if (header_parser_rdy !== 1'b1) begin errors++; $display("FAIL rst_rdy got %0b want 1", header_parser_rdy); end
        checks++; if ({err_missing_hdr, err_bad_dst, err_overflow} !== 3'b000) begin errors++; $display("FAIL rst_errs got %b want 000", {err_missing_hdr, err_bad_dst, err_overflow}); end
        checks++; if (dbg_state !== WAIT_HDR) begin errors++; $display("FAIL rst_state got %0d want %0d", dbg_state, WAIT_HDR); end
`ifdef OQ_HDR_PARSER_STATS_EN
        checks++; if ({missing_hdr_cnt, bad_dst_cnt, overflow_cnt} !== 48'h0) begin errors++; $display("FAIL rst_cnts got %h want 0", {missing_hdr_cnt, bad_dst_cnt, overflow_cnt}); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        send_hdr(8'h04, 11'd64, 8'd8, 16'h0001);
        checks++; if (dst_oq_avail !== 1'b1) begin errors++; $display("FAIL basic_avail got %0b want 1", dst_oq_avail); end
        checks++; if (parsed_dst_oq !== 8'h04) begin errors++; $display("FAIL basic_dst got %h want 04", parsed_dst_oq); end
        checks++; if (parsed_pkt_byte_len !== 11'd64) begin errors++; $display("FAIL basic_bytes got %0d want 64", parsed_pkt_byte_len); end
        checks++; if (parsed_pkt_word_len !== 8'd8) begin errors++; $display("FAIL basic_words got %0d want 8", parsed_pkt_word_len); end
        checks++; if (parsed_src_port !== 16'h0001) begin errors++; $display("FAIL basic_src got %h want 0001", parsed_src_port); end
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL basic_count got %0d want 1", fifo_count); end
        checks++; if (dbg_state !== WAIT_DATA) begin errors++; $display("FAIL basic_state got %0d want %0d", dbg_state, WAIT_DATA); end
        send_body(8);
        checks++; if (dbg_state !== WAIT_HDR) begin errors++; $display("FAIL basic_eop_state got %0d want %0d", dbg_state, WAIT_HDR); end
        checks++; if (fifo_count !== 4'd1) begin errors++; $display("FAIL basic_count_eop got %0d want 1", fifo_count); end
        pop();
        checks++; if (fifo_count !== 4'd0 || dst_oq_avail !== 1'b0) begin errors++; $display("FAIL basic_pop got count %0d avail %0b want 0 0", fifo_count, dst_oq_avail); end
    endtask

    task automatic test_missing_hdr();
        send(8'h00, 64'h1111_2222_3333_4444);
        checks++; if (err_missing_hdr !== 1'b1) begin errors++; $display("FAIL miss_pulse got %0b want 1", err_missing_hdr); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL miss_count got %0d want 0", fifo_count); end
        checks++; if (dbg_state !== DROP_EOP) begin errors++; $display("FAIL miss_state got %0d want %0d", dbg_state, DROP_EOP); end
        send(8'h00, 64'h5);
        checks++; if (err_missing_hdr !== 1'b0) begin errors++; $display("FAIL miss_one_cycle got %0b want 0", err_missing_hdr); end
        send(8'h80, 64'h6);
        send_hdr(8'h02, 11'd128, 8'd16, 16'h0010);
        checks++; if (parsed_dst_oq !== 8'h02 || parsed_pkt_byte_len !== 11'd128 || fifo_count !== 4'd1) begin errors++;
            $display("FAIL miss_next got dst %h len %0d cnt %0d want 02 128 1", parsed_dst_oq, parsed_pkt_byte_len, fifo_count); end
        send_body(2);
        pop();
    endtask

    task automatic test_bad_dst();
        send_hdr(8'h00, 11'd100, 8'd13, 16'h0020);
        checks++; if (err_bad_dst !== 1'b1) begin errors++; $display("FAIL bad_pulse got %0b want 1", err_bad_dst); end
        checks++; if (fifo_count !== 4'd0 || dst_oq_avail !== 1'b0) begin errors++; $display("FAIL bad_fifo got cnt %0d avail %0b want 0 0", fifo_count, dst_oq_avail); end
        checks++; if (dbg_state !== DROP_DATA) begin errors++; $display("FAIL bad_state got %0d want %0d", dbg_state, DROP_DATA); end
        send_body(3);
        checks++; if (err_bad_dst !== 1'b0 || dbg_state !== WAIT_HDR) begin errors++; $display("FAIL bad_after got pulse %0b state %0d want 0 %0d", err_bad_dst, dbg_state, WAIT_HDR); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) begin
            exp_len = 11'd64 + 11'(i);
            send_hdr(8'h01 << i, exp_len, 8'd8, 16'(i));
            exp_q.push_back(exp_len);
            send_body(2);
        end
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_fill got %0d want 8", fifo_count); end
        checks++; if (header_parser_rdy !== 1'b0) begin errors++; $display("FAIL ovf_rdy got %0b want 0", header_parser_rdy); end
        send_hdr(8'h01, 11'd200, 8'd25, 16'h0009);
        checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse got %0b want 1", err_overflow); end
        checks++; if (fifo_count !== 4'd8 || dbg_state !== DROP_DATA) begin errors++; $display("FAIL ovf_drop got cnt %0d state %0d want 8 %0d", fifo_count, dbg_state, DROP_DATA); end
        send_body(2);
`ifdef OQ_HDR_PARSER_STATS_EN
        checks++; if (overflow_cnt !== 16'd1) begin errors++; $display("FAIL ovf_cnt got %0d want 1", overflow_cnt); end
        checks++; if (missing_hdr_cnt !== 16'd1) begin errors++; $display("FAIL miss_cnt got %0d want 1", missing_hdr_cnt); end
        checks++; if (bad_dst_cnt !== 16'd1) begin errors++; $display("FAIL bad_cnt got %0d want 1", bad_dst_cnt); end
`endif
    endtask

    task automatic test_full_rw();
        rd_dst_oq = 1'b1;
        send_hdr(8'h80, 11'd300, 8'd38, 16'h00aa);
        rd_dst_oq = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(11'd300);
        checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL fullrw_count got %0d want 8", fifo_count); end
        checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL fullrw_err got %0b want 0", err_overflow); end
        checks++; if (dbg_state !== WAIT_DATA) begin errors++; $display("FAIL fullrw_state got %0d want %0d", dbg_state, WAIT_DATA); end
        send_body(2);
        for (int i = 0; i < 8; i++) begin
            exp_len = exp_q.pop_front();
            checks++; if (parsed_pkt_byte_len !== exp_len) begin errors++; $display("FAIL drain_%0d got %0d want %0d", i, parsed_pkt_byte_len, exp_len); end
            pop();
        end
        pop();
        checks++; if (fifo_count !== 4'd0 || dst_oq_avail !== 1'b0 || header_parser_rdy !== 1'b1) begin errors++;
            $display("FAIL empty_pop got cnt %0d avail %0b rdy %0b want 0 0 1", fifo_count, dst_oq_avail, header_parser_rdy); end
    endtask

    task automatic test_reset_mid();
        send_hdr(8'h08, 11'd64, 8'd8, 16'h0003);
        send(8'h00, 64'h77);
        checks++; if (fifo_count !== 4'd1 || dbg_state !== WAIT_EOP) begin errors++; $display("FAIL mid_pre got cnt %0d state %0d want 1 %0d", fifo_count, dbg_state, WAIT_EOP); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (dbg_state !== WAIT_HDR) begin errors++; $display("FAIL mid_state got %0d want %0d", dbg_state, WAIT_HDR); end
        checks++; if (fifo_count !== 4'd0 || dst_oq_avail !== 1'b0 || header_parser_rdy !== 1'b1) begin errors++;
            $display("FAIL mid_fifo got cnt %0d avail %0b rdy %0b want 0 0 1", fifo_count, dst_oq_avail, header_parser_rdy); end
`ifdef OQ_HDR_PARSER_STATS_EN
        checks++; if ({missing_hdr_cnt, bad_dst_cnt, overflow_cnt} !== 48'h0) begin errors++; $display("FAIL mid_cnts got %h want 0", {missing_hdr_cnt, bad_dst_cnt, overflow_cnt}); end
`endif
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(8'h00, 64'h78);
        checks++; if (err_missing_hdr !== 1'b1 || fifo_count !== 4'd0) begin errors++; $display("FAIL mid_after got pulse %0b cnt %0d want 1 0", err_missing_hdr, fifo_count); end
        send(8'h80, 64'h79);
    endtask

`ifdef OQ_HDR_PARSER_STATS_EN
    task automatic test_clr_stats();
        checks++; if (missing_hdr_cnt !== 16'd1) begin errors++; $display("FAIL clr_pre got %0d want 1", missing_hdr_cnt); end
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        checks++; if (missing_hdr_cnt !== 16'd0) begin errors++; $display("FAIL clr_zero got %0d want 0", missing_hdr_cnt); end
        send(8'h00, 64'h1);
        clr_stats = 1'b1;
        send(8'h80, 64'h2);
        clr_stats = 1'b0;
        checks++; if (missing_hdr_cnt !== 16'd0) begin errors++; $display("FAIL clr_prio got %0d want 0", missing_hdr_cnt); end
    endtask
`endif

    initial begin
        in_wr     = 1'b0;
        in_ctrl   = 8'h00;
        in_data   = 64'h0;
        rd_dst_oq = 1'b0;
`ifdef OQ_HDR_PARSER_STATS_EN
        clr_stats = 1'b0;
`endif
        test_reset();
        test_basic();
        test_missing_hdr();
        test_bad_dst();
        test_overflow();
        test_full_rw();
        test_reset_mid();
`ifdef OQ_HDR_PARSER_STATS_EN
        test_clr_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/oq_header_parser_v2.md
OQ_HEADER_PARSER_V2 -- requirements
Module: oq_header_parser_v2

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: packet bus data width.
REQ-002 SHALL have parameter CTRL_WIDTH, default DATA_WIDTH/8: packet bus ctrl width.
REQ-003 SHALL have parameter IOQ_STAGE_NUM, default `IO_QUEUE_STAGE_NUM: ctrl value marking the IOQ module header.
REQ-004 SHALL have parameter NUM_OUTPUT_QUEUES, default 8: one-hot destination width.
REQ-005 SHALL have parameter MAX_PKT, default 2048: maximum packet bytes; PKT_BYTE_CNT_WIDTH=log2(MAX_PKT), PKT_WORD_CNT_WIDTH=log2(MAX_PKT/CTRL_WIDTH).
REQ-006 SHALL have parameter SRC_PORT_WIDTH, default 16: source-port field width.
REQ-007 SHALL have parameter FIFO_DEPTH_BITS, default 3: descriptor FIFO depth 2**FIFO_DEPTH_BITS.
REQ-008 SHALL have parameter ERR_CNT_WIDTH, default 16: error counter width.
REQ-009 Ports: clk in 1 clock; reset_n in 1 asynchronous active-low reset.
REQ-010 Ports: in_wr in 1; in_ctrl in CTRL_WIDTH; in_data in DATA_WIDTH -- packet bus, no backpressure.
REQ-011 Ports: parsed_dst_oq out NUM_OUTPUT_QUEUES; parsed_pkt_byte_len out PKT_BYTE_CNT_WIDTH; parsed_pkt_word_len out PKT_WORD_CNT_WIDTH; parsed_src_port out SRC_PORT_WIDTH -- FIFO head descriptor.
REQ-012 Ports: dst_oq_avail out 1 (FIFO not empty); rd_dst_oq in 1 (pop head); header_parser_rdy out 1 (FIFO not full); fifo_count out FIFO_DEPTH_BITS+1.
REQ-013 Ports: err_missing_hdr, err_bad_dst, err_overflow out 1 each -- single-cycle error pulses.
REQ-014 Ports (OQ_HDR_PARSER_STATS_EN only): clr_stats in 1; missing_hdr_cnt, bad_dst_cnt, overflow_cnt out ERR_CNT_WIDTH each.

Function
REQ-015 Descriptor fields SHALL be taken from in_data at `IOQ_DST_PORT_POS, `IOQ_BYTE_LEN_POS, `IOQ_WORD_LEN_POS, `IOQ_SRC_PORT_POS on the IOQ header word.
REQ-016 FSM states: WAIT_HDR, WAIT_DATA, WAIT_EOP, DROP_DATA, DROP_EOP; all transitions only on in_wr=1.
REQ-017 WAIT_HDR, ctrl==IOQ_STAGE_NUM, dst_oq nonzero, FIFO not full: write descriptor same cycle, go WAIT_DATA.
REQ-018 WAIT_HDR, ctrl==IOQ_STAGE_NUM, dst_oq==0: no write, pulse err_bad_dst, go DROP_DATA.
REQ-019 WAIT_HDR, ctrl==IOQ_STAGE_NUM, dst_oq nonzero, FIFO full (and no same-cycle pop): no write, pulse err_overflow, go DROP_DATA; full with simultaneous rd_dst_oq SHALL write normally.
REQ-020 WAIT_HDR, other nonzero ctrl (other module headers): stay.
REQ-021 WAIT_HDR, ctrl==0: pulse err_missing_hdr, go DROP_EOP.
REQ-022 WAIT_DATA/DROP_DATA, ctrl==0: go WAIT_EOP/DROP_EOP; other ctrl: stay.
REQ-023 WAIT_EOP/DROP_EOP, ctrl!=0: go WAIT_HDR.
REQ-024 FIFO SHALL be fall-through: descriptor visible on outputs the cycle after write; dst_oq_avail same cycle.
REQ-025 rd_dst_oq while empty SHALL be ignored; simultaneous read and write on non-empty FIFO SHALL keep fifo_count unchanged.
REQ-026 fifo_count SHALL equal stored descriptors, range 0..2**FIFO_DEPTH_BITS.

Reset
REQ-027 reset_n low SHALL asynchronously set FSM to WAIT_HDR, empty FIFO (fifo_count=0, dst_oq_avail=0, header_parser_rdy=1), clear error pulses and counters.
REQ-028 Reset mid-packet SHALL discard partial packet; next accepted word must be a header.

Configuration
REQ-029 Macro OQ_HDR_PARSER_STATS_EN defined: saturating counters increment on each error pulse; clr_stats zeroes them (increment in same cycle loses to clear).
REQ-030 Macro undefined: clr_stats and counter ports absent; pulses remain.

Structure
REQ-031 State encodings and header-field position macros SHALL live in the shared NF2 defines package.
REQ-032 Descriptor storage SHALL be a sub-module fallthrough_small_fifo parameterised by WIDTH and MAX_DEPTH_BITS.

Verification
REQ-033 Header dst=0x04, len 64B/8W, then 8 data words: descriptor 0x04/64/8 available next cycle, fifo_count=1.
REQ-034 Data word (ctrl=0) with no header: err_missing_hdr one cycle, no write, next valid packet parsed.
REQ-035 Header dst=0x00: err_bad_dst pulse, packet skipped, FIFO unchanged.
REQ-036 Nine packets, depth 8, no reads: ninth gives err_overflow, overflow_cnt=1, header_parser_rdy=0.
REQ-037 Full FIFO, header coincident with rd_dst_oq: written, fifo_count stays 8, no error.
REQ-038 reset_n asserted mid-packet: FSM WAIT_HDR, fifo_count=0 immediately without a clock edge.
